// File: rtl/pll40_pkg.sv
// pll40_pkg: shared lock-state type, widths and NCO modulus helper for the pll40 core model
package pll40_pkg;

    localparam int ACC_W    = 28;
    localparam int PERIOD_W = 16;

    typedef enum logic {SEARCH, LOCKED} lock_state_e;

    function automatic logic [ACC_W-1:0] pll40_mod(
        input logic [ACC_W-1:0] p,
        input logic [3:0]       divr,
        input logic [2:0]       divq
    );
        return (p * (ACC_W'(divr) + ACC_W'(1))) << divq;
    endfunction

endpackage

// File: rtl/pll40_period_meter.sv
// pll40_period_meter: synchronises the reference clock and measures its period in clk cycles
// Ports: clk, rst (sync active-high); ref_clk async reference; ref_sync synchronised level;
//        period P of the measurement ending now; meas_valid one-cycle strobe; ref_lost counter saturated.
module pll40_period_meter
    import pll40_pkg::*;
#(
    parameter int W = PERIOD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ref_clk,
    output logic         ref_sync,
    output logic [W-1:0] period,
    output logic         meas_valid,
    output logic         ref_lost
);

    logic         s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, armed_q, armed_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         edge_det, sat;

    // armed_q: an edge has started a count, so the next edge completes a measurement.
    // A saturated counter disarms, because its value no longer describes a real period.
    // When an edge and saturation coincide the edge wins: it restarts counting and re-arms.
    always_comb begin
        s1_d       = ref_clk;
        s2_d       = s1_q;
        prev_d     = s2_q;
        edge_det   = s2_q & ~prev_q;
        sat        = &cnt_q;
        ref_sync   = s2_q;
        period     = cnt_q + W'(1);
        meas_valid = edge_det & armed_q & ~sat;
        ref_lost   = sat & ~edge_det;
        cnt_d      = edge_det ? '0 : (sat ? cnt_q : cnt_q + W'(1));
        armed_d    = edge_det | (armed_q & ~sat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pll40_core_model.sv
// pll40_core_model: clock-enable NCO replacement for the iCE40 SB_PLL40_CORE (SIMPLE feedback)
// Ports: clk system clock; rst sync active-high reset; RESETB active-low soft reset;
//        BYPASS routes the synchronised reference out; REFERENCECLK async reference;
//        PLLOUTCORE registered synthesised clock; LOCK registered frequency-lock flag.
module pll40_core_model #(
    parameter             FEEDBACK_PATH = "SIMPLE",
    parameter logic [3:0] DIVR          = 4'd0,
    parameter logic [6:0] DIVF          = 7'd33,
    parameter logic [2:0] DIVQ          = 3'd1,
    parameter logic [2:0] FILTER_RANGE  = 3'd1,
    parameter int         LOCK_COUNT    = 4,
    parameter int         PERIOD_W      = pll40_pkg::PERIOD_W
) (
    input  logic clk,
    input  logic rst,
    input  logic RESETB,
    input  logic BYPASS,
    input  logic REFERENCECLK,
    output logic PLLOUTCORE,
    output logic LOCK
);

    import pll40_pkg::*;

    if (FEEDBACK_PATH != "SIMPLE") begin : g_bad_feedback
        $error("pll40_core_model: only SIMPLE feedback is modelled");
    end

    localparam int               MW  = $clog2(LOCK_COUNT + 2);
    localparam logic [ACC_W-1:0] INC = ACC_W'(DIVF) + ACC_W'(1);

    lock_state_e         state_q, state_d;
    logic [MW-1:0]       match_q, match_d, match_inc;
    logic [PERIOD_W-1:0] p_prev_q, p_prev_d, period, diff;
    logic [ACC_W-1:0]    acc_q, acc_d, mod_q, mod_d, mod_next_q, mod_next_d, mod_new, acc_sum;
    logic                out_q, out_d, rst_i, ref_sync, meas_valid, ref_lost;
    logic                in_tol, range_ok, meas_ok, wrap, locked;

    assign rst_i      = rst | ~RESETB;
    assign locked     = state_q == LOCKED;
    assign LOCK       = locked;
    assign PLLOUTCORE = out_q;

    pll40_period_meter #(.W(PERIOD_W)) u_meter (
        .clk        (clk),
        .rst        (rst_i),
        .ref_clk    (REFERENCECLK),
        .ref_sync   (ref_sync),
        .period     (period),
        .meas_valid (meas_valid),
        .ref_lost   (ref_lost)
    );

    // mod_next_q holds the modulus of the latest measurement; it only replaces mod_q
    // when the accumulator wraps, so a period update never truncates an output phase.
    always_comb begin
        diff       = period >= p_prev_q ? period - p_prev_q : p_prev_q - period;
        in_tol     = diff <= PERIOD_W'(FILTER_RANGE);
        mod_new    = pll40_mod(ACC_W'(period), DIVR, DIVQ);
        range_ok   = (INC << 1) <= mod_new;
        meas_ok    = in_tol & range_ok;
        match_inc  = match_q == MW'(LOCK_COUNT) ? match_q : match_q + MW'(1);
        acc_sum    = acc_q + INC;
        wrap       = acc_sum >= mod_q;
        state_d    = state_q;
        match_d    = match_q;
        p_prev_d   = p_prev_q;
        mod_next_d = mod_next_q;
        if (ref_lost) begin
            state_d  = SEARCH;
            match_d  = '0;
            p_prev_d = '0;
        end else if (meas_valid) begin
            p_prev_d   = period;
            match_d    = in_tol ? match_inc : '0;
            mod_next_d = mod_new;
            if (!locked && meas_ok && match_inc >= MW'(LOCK_COUNT)) state_d = LOCKED;
            if (locked && !meas_ok) begin
                state_d = SEARCH;
                match_d = '0;
            end
        end
        acc_d = locked && state_d == LOCKED ? (wrap ? acc_sum - mod_q : acc_sum) : '0;
        mod_d = locked ? (wrap ? mod_next_q : mod_q) : (state_d == LOCKED ? mod_new : mod_q);
        out_d = BYPASS ? ref_sync : locked && acc_q < (mod_q >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= SEARCH;
            match_q    <= '0;
            p_prev_q   <= '0;
            acc_q      <= '0;
            mod_q      <= '0;
            mod_next_q <= '0;
            out_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            p_prev_q   <= p_prev_d;
            acc_q      <= acc_d;
            mod_q      <= mod_d;
            mod_next_q <= mod_next_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: tb/tb_pll40_core_model.sv
// tb_pll40_core_model: scoreboard bench for the PLL model (lockable and range-failing instances)
module tb_pll40_core_model;

    logic clk = 1'b0;
    logic rst, resetb, bypass, ref_clk;
    logic out_a, lock_a, out_b, lock_b;

    always #5 clk = ~clk;

    // INC=4, MOD=20*2=40: lockable, output period 10 clk
    pll40_core_model #(.DIVF(7'd3)) dut (
        .clk          (clk),
        .rst          (rst),
        .RESETB       (resetb),
        .BYPASS       (bypass),
        .REFERENCECLK (ref_clk),
        .PLLOUTCORE   (out_a),
        .LOCK         (lock_a)
    );

    // INC=34, 2*INC=68 > MOD=40: must never lock
    pll40_core_model #(.DIVF(7'd33)) dut_r (
        .clk          (clk),
        .rst          (rst),
        .RESETB       (resetb),
        .BYPASS       (bypass),
        .REFERENCECLK (ref_clk),
        .PLLOUTCORE   (out_b),
        .LOCK         (lock_b)
    );

    typedef struct {
        bit byp;
        bit refv;
        bit lk0;
        bit lk1;
    } exp_t;

    exp_t sb[$];
    int   vectors, miscompares;

    // reference model state (time in bench iterations of one clk each)
    int t, last_rise, p_prev;
    bit ref_prev, armed;
    int mc[2];
    bit lk[2];
    bit plk0, plk1;
    int ph0, ph1;

    task automatic check(input string tag, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic upd(input int k, input int inc, input int p, input bit tol);
        bit rok;
        rok   = 2 * inc <= p * 2;
        mc[k] = tol ? (mc[k] < 4 ? mc[k] + 1 : 4) : 0;
        if (!lk[k]) lk[k] = tol && rok && mc[k] >= 4;
        else if (!(tol && rok)) begin
            lk[k] = 1'b0;
            mc[k] = 0;
        end
    endtask

    task automatic model_reset();
        ref_prev  = 1'b0;
        armed     = 1'b0;
        p_prev    = 0;
        last_rise = t;
        mc[0]     = 0;
        mc[1]     = 0;
        lk[0]     = 1'b0;
        lk[1]     = 1'b0;
        plk0      = 1'b0;
        plk1      = 1'b0;
        ph0       = 0;
        ph1       = 0;
    endtask

    // one clk: compare the entry pushed three cycles ago, then drive and predict
    task automatic step(input bit r);
        exp_t e;
        int   p;
        bit   tol;
        @(negedge clk);
        if (sb.size() == 3) begin
            e = sb.pop_front();
            check("lock",   lock_a, e.lk0);
            check("lock_r", lock_b, e.lk1);
            check("out",    out_a,  e.byp ? e.refv : (plk0 && (ph0 % 10) < 5));
            check("out_r",  out_b,  e.byp ? e.refv : (plk1 && (ph1 % 10) < 5));
            ph0  = e.lk0 ? (plk0 ? ph0 + 1 : 0) : 0;
            ph1  = e.lk1 ? (plk1 ? ph1 + 1 : 0) : 0;
            plk0 = e.lk0;
            plk1 = e.lk1;
        end
        ref_clk = r;
        t++;
        if (r && !ref_prev) begin
            if (armed && t - last_rise <= 65535) begin
                p   = t - last_rise;
                tol = (p > p_prev ? p - p_prev : p_prev - p) <= 1;
                upd(0, 4, p, tol);
                upd(1, 34, p, tol);
                p_prev = p;
            end
            armed     = 1'b1;
            last_rise = t;
        end else if (t - last_rise >= 65536) begin
            lk[0]  = 1'b0;
            lk[1]  = 1'b0;
            mc[0]  = 0;
            mc[1]  = 0;
            p_prev = 0;
            armed  = 1'b0;
        end
        ref_prev = r;
        e.byp  = bypass;
        e.refv = r;
        e.lk0  = lk[0];
        e.lk1  = lk[1];
        sb.push_back(e);
    endtask

    task automatic period(input int hi, input int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    // one-clk reset pulse; both outputs of both instances must read 0 on the next cycle
    task automatic do_reset(input bit use_n, input bit byp);
        @(negedge clk);
        sb.delete();
        ref_clk = 1'b0;
        bypass  = byp;
        if (use_n) resetb = 1'b0;
        else rst = 1'b1;
        @(negedge clk);
        check(use_n ? "resetb_lock"   : "rst_lock",   lock_a, 1'b0);
        check(use_n ? "resetb_out"    : "rst_out",    out_a,  1'b0);
        check(use_n ? "resetb_lock_r" : "rst_lock_r", lock_b, 1'b0);
        check(use_n ? "resetb_out_r"  : "rst_out_r",  out_b,  1'b0);
        rst    = 1'b0;
        resetb = 1'b1;
        model_reset();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        t           = 0;
        rst         = 1'b1;
        resetb      = 1'b1;
        bypass      = 1'b0;
        ref_clk     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset(1'b0, 1'b0);
        repeat (12) period(10, 10);
        period(10, 14);
        repeat (10) period(10, 10);
        do_reset(1'b0, 1'b0);
        repeat (8) period(10, 10);
        do_reset(1'b1, 1'b0);
        do_reset(1'b0, 1'b1);
        repeat (8) period(10, 10);
        do_reset(1'b0, 1'b0);
        repeat (8) period(10, 10);
        repeat (65600) step(1'b0);
        repeat (8) period(10, 10);
        repeat (3) step(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
